// File: rtl/ad9866_spi_sched.sv
// ad9866_spi_sched: arbitrates coalesced RX/TX gain writes and a one-entry host write
// onto the AD9866 SPI engine through a start/busy handshake.
module ad9866_spi_sched #(
    parameter int         GAP_CYCLES   = 4,
    parameter int         ACK_TIMEOUT  = 8,
    parameter logic [4:0] RX_GAIN_ADDR = 5'h09,
    parameter logic [4:0] TX_GAIN_ADDR = 5'h0A
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_init_done,
    input  logic        i_ptt,
    input  logic [5:0]  i_rx_gain,
    input  logic [5:0]  i_tx_gain,
    input  logic        i_cmd_valid,
    input  logic [4:0]  i_cmd_addr,
    input  logic [7:0]  i_cmd_data,
    output logic        o_cmd_ready,
    output logic        o_spi_start,
    output logic [15:0] o_spi_word,
    input  logic        i_spi_busy,
    output logic        o_err_timeout,
    output logic        o_idle
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_GAP} state_t;
    typedef enum logic [1:0] {W_RX, W_TX, W_HOST} win_t;
    localparam int CMAX = GAP_CYCLES > ACK_TIMEOUT ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int CW   = $clog2(CMAX) + 1;

    state_t        r_state, w_next;
    win_t          r_win, w_win;
    logic [CW-1:0] r_cnt;
    logic          r_rx_pend, r_tx_pend, r_hvalid, r_last_host, r_err;
    logic [5:0]    r_rx_sh, r_tx_sh;
    logic [4:0]    r_haddr;
    logic [7:0]    r_hdata;
    logic [15:0]   r_word;
    logic          w_gain_any, w_go, w_timeout, w_gap_last, w_take_rx, w_take_tx;

    assign w_gain_any = r_rx_pend | r_tx_pend;
    assign w_go       = r_state == S_IDLE && i_init_done && (r_hvalid || w_gain_any);
    // host yields to pending gain writes right after it has won once
    assign w_win      = (r_hvalid && (!r_last_host || !w_gain_any)) ? W_HOST :
                        i_ptt ? (r_tx_pend ? W_TX : W_RX) : (r_rx_pend ? W_RX : W_TX);
    assign w_timeout  = r_state == S_WAIT_ACK && !i_spi_busy && r_cnt == CW'(ACK_TIMEOUT - 1);
    assign w_gap_last = r_cnt == CW'(GAP_CYCLES - 1);
    assign w_take_rx  = w_go && w_win == W_RX;
    assign w_take_tx  = w_go && w_win == W_TX;

    assign o_cmd_ready   = !r_hvalid;
    assign o_spi_start   = r_state == S_ISSUE;
    assign o_spi_word    = r_word;
    assign o_err_timeout = r_err;
    assign o_idle        = r_state == S_IDLE && !r_hvalid && !w_gain_any;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      w_next = w_go ? S_ISSUE : S_IDLE;
            S_ISSUE:     w_next = S_WAIT_ACK;
            S_WAIT_ACK:  w_next = i_spi_busy ? S_WAIT_DONE : (w_timeout ? S_GAP : S_WAIT_ACK);
            S_WAIT_DONE: w_next = i_spi_busy ? S_WAIT_DONE : S_GAP;
            S_GAP:       w_next = w_gap_last ? S_IDLE : S_GAP;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt       <= '0;
            r_win       <= W_RX;
            r_rx_pend   <= 1'b1;
            r_tx_pend   <= 1'b1;
            r_rx_sh     <= '0;
            r_tx_sh     <= '0;
            r_hvalid    <= 1'b0;
            r_haddr     <= '0;
            r_hdata     <= '0;
            r_last_host <= 1'b0;
            r_err       <= 1'b0;
            r_word      <= '0;
        end else begin
            r_cnt <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            if (w_go) begin
                r_win       <= w_win;
                r_last_host <= w_win == W_HOST;
                r_word      <= w_win == W_HOST ? {3'b000, r_haddr, r_hdata} :
                               w_win == W_TX   ? {3'b000, TX_GAIN_ADDR, 2'b01, i_tx_gain} :
                                                 {3'b000, RX_GAIN_ADDR, 2'b01, i_rx_gain};
            end
            // a timed-out gain write is re-armed so it gets retried
            r_rx_pend <= w_take_rx ? 1'b0 :
                         r_rx_pend || i_rx_gain != r_rx_sh || (w_timeout && r_win == W_RX);
            r_tx_pend <= w_take_tx ? 1'b0 :
                         r_tx_pend || i_tx_gain != r_tx_sh || (w_timeout && r_win == W_TX);
            if (w_take_rx) r_rx_sh <= i_rx_gain;
            if (w_take_tx) r_tx_sh <= i_tx_gain;
            r_hvalid <= (w_go && w_win == W_HOST) ? 1'b0 : r_hvalid | i_cmd_valid;
            if (i_cmd_valid && !r_hvalid) begin
                r_haddr <= i_cmd_addr;
                r_hdata <= i_cmd_data;
            end
            r_err <= r_err | w_timeout;
        end
    end
endmodule

// File: tb/tb_ad9866_spi_sched.sv
// tb_ad9866_spi_sched: directed checks of arbitration, coalescing, timeout retry,
// reset abort and init gating against a small busy-responding engine model.
module tb_ad9866_spi_sched;
    logic        clk = 0, reset = 1, init_done = 1, ptt = 0;
    logic [5:0]  rx_gain = 6'h2A, tx_gain = 6'h00;
    logic        cmd_valid = 0;
    logic [4:0]  cmd_addr = 0;
    logic [7:0]  cmd_data = 0;
    logic        cmd_ready, spi_start, spi_busy, err_timeout, idle;
    logic [15:0] spi_word;
    logic        eng_on = 1;
    logic [15:0] q_w[$];
    longint      q_t[$];
    int          total = 0, bad = 0;

    ad9866_spi_sched dut (
        .i_clk(clk), .i_reset(reset), .i_init_done(init_done), .i_ptt(ptt),
        .i_rx_gain(rx_gain), .i_tx_gain(tx_gain),
        .i_cmd_valid(cmd_valid), .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
        .o_cmd_ready(cmd_ready), .o_spi_start(spi_start), .o_spi_word(spi_word),
        .i_spi_busy(spi_busy), .o_err_timeout(err_timeout), .o_idle(idle)
    );

    initial forever #5 clk = ~clk;

    // engine model: logs every start; when enabled holds busy for 4 cycles
    initial begin
        spi_busy = 0;
        forever begin
            @(negedge clk);
            if (spi_start === 1'b1) begin
                q_w.push_back(spi_word);
                q_t.push_back($time);
                if (eng_on) begin
                    spi_busy = 1;
                    repeat (4) @(negedge clk);
                    spi_busy = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] wd(input int i);
        return i < q_w.size() ? q_w[i] : 16'hDEAD;
    endfunction

    task automatic wait_start(input string tag);
        int n = 0;
        while (spi_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, {31'd0, spi_start}, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (idle !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, {31'd0, idle}, 1);
    endtask

    task automatic send_cmd(input logic [4:0] a, input logic [7:0] d);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 1);
        cmd_valid = 1;
        cmd_addr  = a;
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    initial begin
        int nh;
        // 1: reset state, then both gains written in RX,TX order
        @(negedge clk);
        chk("rst_start", {31'd0, spi_start}, 0);
        chk("rst_word", {16'd0, spi_word}, 0);
        chk("rst_ready", {31'd0, cmd_ready}, 1);
        chk("rst_err", {31'd0, err_timeout}, 0);
        chk("rst_idle", {31'd0, idle}, 0);
        reset = 0;
        wait_start("t1");
        wait_idle("t1");
        chk("t1_n", q_w.size(), 2);
        chk("t1_w0", {16'd0, wd(0)}, 32'h096A);
        chk("t1_w1", {16'd0, wd(1)}, 32'h0A40);
        chk("t1_spacing", 32'((q_t[1] - q_t[0]) / 10), 10);

        // 2: three RX changes inside a TX busy window coalesce into one write
        q_w.delete();
        tx_gain = 6'h03;
        wait_start("t2");
        @(negedge clk) rx_gain = 6'h01;
        @(negedge clk) rx_gain = 6'h05;
        @(negedge clk) rx_gain = 6'h10;
        wait_idle("t2");
        chk("t2_n", q_w.size(), 2);
        chk("t2_w0", {16'd0, wd(0)}, 32'h0A43);
        chk("t2_w1", {16'd0, wd(1)}, 32'h0950);

        // 3: host vs gain alternation with ptt=1
        q_w.delete();
        init_done = 0;
        ptt = 1;
        rx_gain = 6'h11;
        tx_gain = 6'h22;
        send_cmd(5'h07, 8'h21);
        chk("t3_full", {31'd0, cmd_ready}, 0);
        repeat (5) @(negedge clk);
        chk("t3_gated", q_w.size(), 0);
        init_done = 1;
        send_cmd(5'h03, 8'h55);
        wait_idle("t3");
        chk("t3_n", q_w.size(), 4);
        chk("t3_w0", {16'd0, wd(0)}, 32'h0721);
        chk("t3_w1", {16'd0, wd(1)}, 32'h0A62);
        chk("t3_w2", {16'd0, wd(2)}, 32'h0355);
        chk("t3_w3", {16'd0, wd(3)}, 32'h0951);

        // 4: engine never acknowledges: sticky error, gain retried, host dropped
        q_w.delete();
        ptt = 0;
        eng_on = 0;
        rx_gain = 6'h3F;
        wait_start("t4");
        chk("t4_word", {16'd0, spi_word}, 32'h097F);
        repeat (8) @(negedge clk);
        chk("t4_err_early", {31'd0, err_timeout}, 0);
        @(negedge clk);
        chk("t4_err", {31'd0, err_timeout}, 1);
        send_cmd(5'h05, 8'hAA);
        chk("t4_full", {31'd0, cmd_ready}, 0);
        repeat (60) @(negedge clk);
        eng_on = 1;
        wait_idle("t4");
        nh = 0;
        foreach (q_w[i]) if (q_w[i] == 16'h05AA) nh++;
        chk("t4_w1", {16'd0, wd(1)}, 32'h05AA);
        chk("t4_w2", {16'd0, wd(2)}, 32'h097F);
        chk("t4_host_once", nh, 1);
        chk("t4_last", {16'd0, wd(q_w.size() - 1)}, 32'h097F);
        chk("t4_ready", {31'd0, cmd_ready}, 1);
        chk("t4_sticky", {31'd0, err_timeout}, 1);

        // 5: asynchronous reset while the engine is busy
        rx_gain = 6'h15;
        tx_gain = 6'h16;
        wait_start("t5");
        repeat (2) @(negedge clk);
        reset = 1;
        #1;
        chk("t5_start", {31'd0, spi_start}, 0);
        chk("t5_word", {16'd0, spi_word}, 0);
        chk("t5_err", {31'd0, err_timeout}, 0);
        chk("t5_idle", {31'd0, idle}, 0);
        chk("t5_ready", {31'd0, cmd_ready}, 1);
        repeat (4) @(negedge clk);
        q_w.delete();
        q_t.delete();
        reset = 0;
        wait_start("t5r");
        wait_idle("t5");
        chk("t5_n", q_w.size(), 2);
        chk("t5_w0", {16'd0, wd(0)}, 32'h0955);
        chk("t5_w1", {16'd0, wd(1)}, 32'h0A56);

        // 6: init_done gating, one-cycle latency, completion after init_done falls
        q_w.delete();
        init_done = 0;
        rx_gain = 6'h2B;
        tx_gain = 6'h2C;
        repeat (20) @(negedge clk);
        chk("t6_none", q_w.size(), 0);
        chk("t6_busy_idle", {31'd0, idle}, 0);
        init_done = 1;
        @(negedge clk);
        chk("t6_latency", {31'd0, spi_start}, 1);
        chk("t6_word", {16'd0, spi_word}, 32'h096B);
        init_done = 0;
        repeat (30) @(negedge clk);
        chk("t6_hold_n", q_w.size(), 1);
        chk("t6_hold_start", {31'd0, spi_start}, 0);
        init_done = 1;
        wait_start("t6");
        wait_idle("t6");
        chk("t6_n", q_w.size(), 2);
        chk("t6_w1", {16'd0, wd(1)}, 32'h0A6C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
